lcd_stream_writer: RTL and testbench
====================================

LCD_STREAM_WRITER -- requirements
Module: lcd_stream_writer

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 480, visible pixels per line; SHALL be a multiple of 8.
REQ-002 SHALL have parameters H_FP 2, H_SYNC 41, H_BP 2, the horizontal front porch, sync and back porch widths in clocks.
REQ-003 SHALL have parameters V_ACTIVE 272, V_FP 2, V_SYNC 10, V_BP 2, the vertical active lines, porches and sync width in lines.
REQ-004 SHALL have parameter COLOR_W, default 8, bits per colour channel; pixel width PW = 3*COLOR_W, ordered R[MSB], G, B[LSB].
REQ-005 SHALL have parameter SYNC_POL, default 0, giving the active level of hsync and vsync.
REQ-006 Ports, one clock; reset is asynchronous and active-high:
  clk_12mhz  in  1  pixel clock
  rst  in  1  asynchronous active-high reset
  rgb_in  in  PW  show-ahead source pixel
  data_valid  in  1  rgb_in valid (source not empty)
  data_req  out  1  pixel consumed this cycle when data_valid is also high
  mode  in  2  0 stream, 1 colour bars, 2 solid, 3 blank
  solid_color  in  PW  colour for mode 2
  underflow_clr  in  1  clears underflow
  rgb_out  out  PW  panel pixel
  hsync, vsync  out  1  sync outputs, SYNC_POL active
  d_en  out  1  data enable
  d_clk  out  1  forwarded pixel clock
  disp_en  out  1  panel enable
  underflow  out  1  sticky starvation flag
  frame_start  out  1  one-cycle pulse at the start of each frame

Function
REQ-007 h_cnt SHALL count 0..H_TOTAL-1, where H_TOTAL = H_SYNC+H_BP+H_ACTIVE+H_FP, with segment order sync, back porch, active, front porch.
REQ-008 v_cnt SHALL increment when h_cnt wraps, count 0..V_TOTAL-1 in the same segment order, and wrap to 0.
REQ-009 A pixel SHALL be active at cycle t when both h_cnt and v_cnt are in their active segments at t.
REQ-010 data_req SHALL be combinational and high exactly when the pixel is active and the latched mode is stream; it SHALL be low in all other modes.
REQ-011 The source SHALL pop only on data_req && data_valid; rgb_in is sampled in the same cycle.
REQ-012 rgb_out, d_en, hsync and vsync SHALL be registered and reflect cycle t's counters and pixel at t+1, giving one cycle of latency, aligned with each other.
REQ-013 d_en SHALL be 1 only for active pixels; rgb_out SHALL be 0 whenever d_en is 0.
REQ-014 If data_req is high and data_valid is low, the pixel SHALL output 0 and the timing SHALL NOT stall.
REQ-015 underflow SHALL be set one cycle after the event in REQ-014 and held until underflow_clr; if a set and clear occur in the same cycle, set wins.
REQ-016 mode and solid_color SHALL be latched only when h_cnt=0 and v_cnt=0, so a mid-frame change takes effect at the next frame.
REQ-017 Colour bars SHALL be 8 equal bars of H_ACTIVE/8 pixels, in the order white, yellow, cyan, green, magenta, red, blue, black, with each channel all-ones or 0.
REQ-018 Bars SHALL be generated by a bar-width counter, not by division.
REQ-019 Blank mode SHALL keep the timing running with d_en active and rgb_out=0.
REQ-020 frame_start SHALL pulse registered, aligned with the first sync cycle output of each frame.
REQ-021 disp_en SHALL rise with the first frame_start after reset and then stay 1.
REQ-022 d_clk SHALL equal the inverted clk_12mhz, so the panel samples mid-pixel, and SHALL be forced 0 while rst is high.

Reset
REQ-023 While rst is high, counters, latched mode and all registered outputs SHALL be reset asynchronously.
REQ-024 Reset output values: rgb_out 0, d_en 0, hsync and vsync at the inactive level (~SYNC_POL), underflow 0, frame_start 0, disp_en 0.
REQ-025 After reset release the latched mode SHALL be 0 (stream).
REQ-026 The first clock after release SHALL be h_cnt=0, v_cnt=0 and SHALL latch mode.
REQ-027 A reset mid-frame SHALL abandon the frame with no residual output.

Structure
REQ-028 Shared package lcd_pkg SHALL hold the mode enum (LCD_STREAM, LCD_BARS, LCD_SOLID, LCD_BLANK), the default timing constants and the 8 bar colours.
REQ-029 Sub-module lcd_axis_counter SHALL be used, parameterised by segment widths, with a count-enable input, a wrap output and active and sync outputs.
REQ-030 lcd_axis_counter SHALL be instantiated once for horizontal and once for vertical.

Verification
Bench parameters: H_ACTIVE=8, H_FP=1, H_SYNC=2, H_BP=1 (12 clk/line); V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=1 (7 lines, 84 clk/frame); COLOR_W=8, SYNC_POL=0.
REQ-031 Free run in blank mode -> per line hsync low 2/12 clk; per frame vsync low 12 clk, d_en high 32 clk, frame_start every 84 clk, disp_en 1 from the first frame_start.
REQ-032 Stream with an always-valid source counting 0,1,2,... -> rgb_out on d_en cycles is 0..31 in order, each one cycle after its data_req, 32 data_req per frame, underflow 0.
REQ-033 Stream with data_valid low on pixel 5 only -> rgb_out for that pixel is 0, the next pixel is 5, underflow 1 until underflow_clr, and a simultaneous set and clear leaves underflow 1.
REQ-034 mode=1 asserted at cycle 20 -> rest of the frame is stream; the next frame's lines are FFFFFF, FFFF00, 00FFFF, 00FF00, FF00FF, FF0000, 0000FF, 000000 and data_req stays 0.
REQ-035 mode=2 with solid_color=123456 -> every d_en pixel is 123456 from the next frame.
REQ-036 rst asserted at pixel 3 of line 2 -> outputs take reset values without waiting for a clock edge; after release the frame restarts with hsync low for 2 clk.

Source files
------------

// File: rtl/lcd_pkg.sv
// Shared types and constants for the LCD stream writer: output modes,
// default panel timing and the colour-bar palette.
package lcd_pkg;

    typedef enum logic [1:0] {
        LCD_STREAM = 2'd0,
        LCD_BARS   = 2'd1,
        LCD_SOLID  = 2'd2,
        LCD_BLANK  = 2'd3
    } lcd_mode_e;

    localparam int DEF_H_ACTIVE = 480;
    localparam int DEF_H_FP     = 2;
    localparam int DEF_H_SYNC   = 41;
    localparam int DEF_H_BP     = 2;
    localparam int DEF_V_ACTIVE = 272;
    localparam int DEF_V_FP     = 2;
    localparam int DEF_V_SYNC   = 10;
    localparam int DEF_V_BP     = 2;
    localparam int DEF_COLOR_W  = 8;

    localparam int BAR_COUNT = 8;

    // Bar colours as {R,G,B} on/off masks, left to right across the line.
    function automatic logic [2:0] bar_mask(input logic [2:0] idx);
        logic [2:0] m;
        case (idx)
            3'd0:    m = 3'b111;  // white
            3'd1:    m = 3'b110;  // yellow
            3'd2:    m = 3'b011;  // cyan
            3'd3:    m = 3'b010;  // green
            3'd4:    m = 3'b101;  // magenta
            3'd5:    m = 3'b100;  // red
            3'd6:    m = 3'b001;  // blue
            default: m = 3'b000;  // black
        endcase
        return m;
    endfunction

endpackage

// File: rtl/lcd_axis_counter.sv
// One timing axis (horizontal or vertical): a wrapping counter split into
// sync, back porch, active and front porch segments.
module lcd_axis_counter #(
    parameter int SYNC   = 2,
    parameter int BP     = 1,
    parameter int ACTIVE = 8,
    parameter int FP     = 1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_en,
    output logic o_wrap,
    output logic o_active,
    output logic o_sync
);

    localparam int TOTAL = SYNC + BP + ACTIVE + FP;
    localparam int CW    = (TOTAL > 1) ? $clog2(TOTAL) : 1;

    localparam logic [CW-1:0] LAST      = CW'(TOTAL - 1);
    localparam logic [CW-1:0] SYNC_END  = CW'(SYNC);
    localparam logic [CW-1:0] ACT_START = CW'(SYNC + BP);
    localparam logic [CW-1:0] ACT_END   = CW'(SYNC + BP + ACTIVE);

    logic [CW-1:0] r_cnt;
    logic          w_last;

    assign w_last = (r_cnt == LAST);

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= '0;
        end else if (i_en) begin
            r_cnt <= w_last ? '0 : r_cnt + 1'b1;
        end
    end

    assign o_wrap   = i_en && w_last;
    assign o_sync   = (r_cnt < SYNC_END);
    assign o_active = (r_cnt >= ACT_START) && (r_cnt < ACT_END);

endmodule

// File: rtl/lcd_stream_writer.sv
// RGB panel driver: generates sync/data-enable timing and fills active
// pixels from a show-ahead stream, colour bars, a solid colour or black.
module lcd_stream_writer
    import lcd_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int COLOR_W  = DEF_COLOR_W,
    parameter bit SYNC_POL = 1'b0
) (
    input  logic                 clk_12mhz,
    input  logic                 rst,
    input  logic [3*COLOR_W-1:0] rgb_in,
    input  logic                 data_valid,
    output logic                 data_req,
    input  logic [1:0]           mode,
    input  logic [3*COLOR_W-1:0] solid_color,
    input  logic                 underflow_clr,
    output logic [3*COLOR_W-1:0] rgb_out,
    output logic                 hsync,
    output logic                 vsync,
    output logic                 d_en,
    output logic                 d_clk,
    output logic                 disp_en,
    output logic                 underflow,
    output logic                 frame_start
);

    localparam int PW     = 3 * COLOR_W;
    localparam int BAR_W  = H_ACTIVE / BAR_COUNT;
    localparam int BAR_CW = (BAR_W > 1) ? $clog2(BAR_W) : 1;

    localparam logic [BAR_CW-1:0] BAR_LAST = BAR_CW'(BAR_W - 1);

    logic w_h_wrap, w_h_active, w_h_sync;
    logic w_v_wrap, w_v_active, w_v_sync;
    logic w_active;
    logic w_starve;

    logic [PW-1:0]     w_pixel;
    logic [2:0]        w_bar_rgb;
    logic              r_origin;
    lcd_mode_e         r_mode;
    logic [PW-1:0]     r_solid;
    logic [BAR_CW-1:0] r_bar_cnt;
    logic [2:0]        r_bar_idx;

    lcd_axis_counter #(
        .SYNC   (H_SYNC),
        .BP     (H_BP),
        .ACTIVE (H_ACTIVE),
        .FP     (H_FP)
    ) u_h_cnt (
        .i_clk    (clk_12mhz),
        .i_rst    (rst),
        .i_en     (1'b1),
        .o_wrap   (w_h_wrap),
        .o_active (w_h_active),
        .o_sync   (w_h_sync)
    );

    lcd_axis_counter #(
        .SYNC   (V_SYNC),
        .BP     (V_BP),
        .ACTIVE (V_ACTIVE),
        .FP     (V_FP)
    ) u_v_cnt (
        .i_clk    (clk_12mhz),
        .i_rst    (rst),
        .i_en     (w_h_wrap),
        .o_wrap   (w_v_wrap),
        .o_active (w_v_active),
        .o_sync   (w_v_sync)
    );

    assign w_active = w_h_active && w_v_active;
    assign data_req = w_active && (r_mode == LCD_STREAM);
    assign w_starve = data_req && !data_valid;
    assign d_clk    = ~clk_12mhz & ~rst;

    // r_origin marks the h=0/v=0 cycle: set by reset and by the frame wrap.
    always_ff @(posedge clk_12mhz or posedge rst) begin
        if (rst) begin
            r_origin <= 1'b1;
            r_mode   <= LCD_STREAM;
            r_solid  <= '0;
        end else begin
            r_origin <= w_v_wrap;
            if (r_origin) begin
                r_mode  <= lcd_mode_e'(mode);
                r_solid <= solid_color;
            end
        end
    end

    always_ff @(posedge clk_12mhz or posedge rst) begin
        if (rst) begin
            r_bar_cnt <= '0;
            r_bar_idx <= '0;
        end else if (!w_active) begin
            r_bar_cnt <= '0;
            r_bar_idx <= '0;
        end else if (r_bar_cnt == BAR_LAST) begin
            r_bar_cnt <= '0;
            r_bar_idx <= r_bar_idx + 3'd1;
        end else begin
            r_bar_cnt <= r_bar_cnt + 1'b1;
        end
    end

    assign w_bar_rgb = bar_mask(r_bar_idx);

    // NOTE: default first so every path assigns w_pixel and no latch is inferred.
    always_comb begin
        w_pixel = '0;
        if (w_active) begin
            case (r_mode)
                LCD_STREAM: if (data_valid) w_pixel = rgb_in;
                LCD_BARS:   w_pixel = {{COLOR_W{w_bar_rgb[2]}},
                                       {COLOR_W{w_bar_rgb[1]}},
                                       {COLOR_W{w_bar_rgb[0]}}};
                LCD_SOLID:  w_pixel = r_solid;
                default:    w_pixel = '0;
            endcase
        end
    end

    always_ff @(posedge clk_12mhz or posedge rst) begin
        if (rst) begin
            rgb_out     <= '0;
            d_en        <= 1'b0;
            hsync       <= ~SYNC_POL;
            vsync       <= ~SYNC_POL;
            frame_start <= 1'b0;
            disp_en     <= 1'b0;
            underflow   <= 1'b0;
        end else begin
            rgb_out     <= w_pixel;
            d_en        <= w_active;
            hsync       <= w_h_sync ? SYNC_POL : ~SYNC_POL;
            vsync       <= w_v_sync ? SYNC_POL : ~SYNC_POL;
            frame_start <= r_origin;
            disp_en     <= disp_en | r_origin;
            // A starvation event in the same cycle as a clear keeps the flag set.
            if (w_starve)           underflow <= 1'b1;
            else if (underflow_clr) underflow <= 1'b0;
        end
    end

endmodule

// File: tb/tb_lcd_stream_writer.sv
// Self-checking bench for lcd_stream_writer on a tiny 12x7 raster; stream
// pixels go through a scoreboard queue from data_req to rgb_out.
module tb_lcd_stream_writer;

    localparam int H_TOT = 12;
    localparam int V_TOT = 7;
    localparam int F_TOT = H_TOT * V_TOT;

    logic        clk_12mhz;
    logic        rst;
    logic [23:0] rgb_in;
    logic        data_valid;
    logic        data_req;
    logic [1:0]  mode;
    logic [23:0] solid_color;
    logic        underflow_clr;
    logic [23:0] rgb_out;
    logic        hsync, vsync, d_en, d_clk, disp_en, underflow, frame_start;

    lcd_stream_writer #(
        .H_ACTIVE (8), .H_FP (1), .H_SYNC (2), .H_BP (1),
        .V_ACTIVE (4), .V_FP (1), .V_SYNC (1), .V_BP (1),
        .COLOR_W  (8), .SYNC_POL (1'b0)
    ) dut (
        .clk_12mhz     (clk_12mhz),
        .rst           (rst),
        .rgb_in        (rgb_in),
        .data_valid    (data_valid),
        .data_req      (data_req),
        .mode          (mode),
        .solid_color   (solid_color),
        .underflow_clr (underflow_clr),
        .rgb_out       (rgb_out),
        .hsync         (hsync),
        .vsync         (vsync),
        .d_en          (d_en),
        .d_clk         (d_clk),
        .disp_en       (disp_en),
        .underflow     (underflow),
        .frame_start   (frame_start)
    );

    initial begin
        clk_12mhz = 1'b0;
        forever #5 clk_12mhz = ~clk_12mhz;
    end

    typedef struct {
        int          c;
        logic [23:0] v;
    } exp_t;

    exp_t        exp_q[$];
    int          total = 0;
    int          bad   = 0;
    int          cyc;
    int          obs;
    int          n_req;
    logic [23:0] src_val;
    logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                              24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

    function automatic bit pix_active(input int c);
        int h, v;
        h = c % H_TOT;
        v = (c / H_TOT) % V_TOT;
        return (h >= 3) && (h < 11) && (v >= 2) && (v < 6);
    endfunction

    function automatic int pix_index(input int c);
        int h, v;
        h = c % H_TOT;
        v = (c / H_TOT) % V_TOT;
        return (v - 2) * 8 + (h - 3);
    endfunction

    // One pixel clock: record stream requests, then sample outputs on the falling edge.
    task automatic tick();
        logic popped;
        exp_t e;
        #1;
        popped = data_req && data_valid;
        if (data_req) begin
            e.c = cyc;
            e.v = data_valid ? rgb_in : 24'h0;
            exp_q.push_back(e);
            n_req++;
        end
        obs = cyc;
        cyc++;
        @(posedge clk_12mhz);
        @(negedge clk_12mhz);
        if (popped) begin
            src_val = src_val + 24'd1;
            rgb_in  = src_val;
        end
    endtask

    task automatic pop_check(input string name);
        exp_t e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL %s obs=%0d got=%h required=queued pixel (queue empty)", name, obs, rgb_out);
        end else begin
            e = exp_q.pop_front();
            if (rgb_out !== e.v || obs !== e.c) begin
                bad++;
                $display("FAIL %s obs=%0d got=%h required=%h (req cycle %0d)", name, obs, rgb_out, e.v, e.c);
            end
        end
    endtask

    task automatic do_reset(input logic [1:0] m);
        rst           = 1'b1;
        mode          = m;
        data_valid    = 1'b1;
        underflow_clr = 1'b0;
        solid_color   = 24'h0;
        src_val       = 24'h0;
        rgb_in        = 24'h0;
        @(negedge clk_12mhz);
        @(negedge clk_12mhz);
        rst   = 1'b0;
        cyc   = 0;
        n_req = 0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1; mode = 2'd0; data_valid = 1'b0; underflow_clr = 1'b0;
        rgb_in = 24'h0; solid_color = 24'h0;
        repeat (3) @(negedge clk_12mhz);
        #1;
        total++;
        if ({rgb_out, d_en, hsync, vsync, underflow, frame_start, disp_en, d_clk} !==
            {24'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL reset_values got rgb=%h den=%b hs=%b vs=%b uf=%b fs=%b de=%b dclk=%b",
                     rgb_out, d_en, hsync, vsync, underflow, frame_start, disp_en, d_clk);
        end
        @(posedge clk_12mhz);
        #1;
        total++;
        if (d_clk !== 1'b0) begin
            bad++;
            $display("FAIL reset_dclk_high got=%b required=0", d_clk);
        end
    endtask

    task automatic test_blank();
        int h, v, hs_low, vs_low, den, fs;
        do_reset(2'd3);
        for (int f = 0; f < 2; f++) begin
            hs_low = 0; vs_low = 0; den = 0; fs = 0; n_req = 0;
            repeat (F_TOT) begin
                tick();
                h = obs % H_TOT;
                v = (obs / H_TOT) % V_TOT;
                total++;
                if ({d_en, hsync, vsync, frame_start, disp_en} !==
                    {pix_active(obs), (h >= 2), (v >= 1), (obs % F_TOT == 0), 1'b1}) begin
                    bad++;
                    $display("FAIL blank_timing obs=%0d got den/hs/vs/fs/de=%b%b%b%b%b", obs,
                             d_en, hsync, vsync, frame_start, disp_en);
                end
                total++;
                if (rgb_out !== 24'h0) begin
                    bad++;
                    $display("FAIL blank_rgb obs=%0d got=%h required=000000", obs, rgb_out);
                end
                hs_low += (hsync === 1'b0) ? 1 : 0;
                vs_low += (vsync === 1'b0) ? 1 : 0;
                den    += (d_en === 1'b1) ? 1 : 0;
                fs     += (frame_start === 1'b1) ? 1 : 0;
            end
            total++;
            if (hs_low != 14 || vs_low != 12 || den != 32 || fs != 1 || n_req != 0) begin
                bad++;
                $display("FAIL blank_counts got hs_low=%0d vs_low=%0d den=%0d fs=%0d req=%0d required 14 12 32 1 0",
                         hs_low, vs_low, den, fs, n_req);
            end
        end
        #1;
        total++;
        if (d_clk !== 1'b1) begin
            bad++;
            $display("FAIL dclk_inverted got=%b required=1 while clk low", d_clk);
        end
    endtask

    task automatic test_stream();
        int npix;
        bit uf_seen;
        do_reset(2'd0);
        npix = 0; uf_seen = 0;
        repeat (F_TOT) begin
            tick();
            if (underflow !== 1'b0) uf_seen = 1;
            if (d_en === 1'b1) begin
                pop_check("stream_scoreboard");
                total++;
                if (rgb_out !== 24'(npix)) begin
                    bad++;
                    $display("FAIL stream_order obs=%0d got=%h required=%h", obs, rgb_out, 24'(npix));
                end
                npix++;
            end
        end
        total++;
        if (n_req != 32 || npix != 32 || uf_seen) begin
            bad++;
            $display("FAIL stream_counts got req=%0d pix=%0d uf_seen=%0d required 32 32 0", n_req, npix, uf_seen);
        end
    endtask

    task automatic test_underflow();
        logic exp_uf;
        do_reset(2'd0);
        repeat (F_TOT) begin
            data_valid    = !(pix_active(cyc) && pix_index(cyc) == 5);
            underflow_clr = (cyc == 60);
            if (cyc == 63) begin
                data_valid    = 1'b0;
                underflow_clr = 1'b1;
            end
            tick();
            if (d_en === 1'b1) begin
                pop_check("underflow_scoreboard");
                if (pix_index(obs) == 5 || pix_index(obs) == 6) begin
                    total++;
                    if (rgb_out !== ((pix_index(obs) == 5) ? 24'h0 : 24'h5)) begin
                        bad++;
                        $display("FAIL underflow_pixel obs=%0d got=%h", obs, rgb_out);
                    end
                end
            end
            exp_uf = (obs >= 32 && obs < 60) || (obs >= 63);
            total++;
            if (underflow !== exp_uf) begin
                bad++;
                $display("FAIL underflow_flag obs=%0d got=%b required=%b", obs, underflow, exp_uf);
            end
        end
        data_valid = 1'b1;
        underflow_clr = 1'b0;
    endtask

    task automatic test_mode_switch();
        int h, nbar;
        do_reset(2'd0);
        repeat (F_TOT) begin
            if (cyc == 20) mode = 2'd1;
            tick();
            if (d_en === 1'b1) pop_check("switch_stream");
        end
        total++;
        if (n_req != 32) begin
            bad++;
            $display("FAIL switch_req_frame0 got=%0d required=32", n_req);
        end
        nbar = 0;
        repeat (F_TOT) begin
            tick();
            h = obs % H_TOT;
            if (d_en === 1'b1) begin
                nbar++;
                total++;
                if (rgb_out !== bars[h-3]) begin
                    bad++;
                    $display("FAIL bars_colour obs=%0d got=%h required=%h", obs, rgb_out, bars[h-3]);
                end
            end
        end
        total++;
        if (n_req != 32 || nbar != 32 || exp_q.size() != 0) begin
            bad++;
            $display("FAIL bars_counts got req=%0d bar_pix=%0d queued=%0d required 32 32 0",
                     n_req, nbar, exp_q.size());
        end
    endtask

    task automatic test_solid();
        int f;
        do_reset(2'd0);
        repeat (F_TOT + F_TOT + 40) begin
            if (cyc == 5)   begin mode = 2'd2; solid_color = 24'h123456; end
            if (cyc == 100) solid_color = 24'hABCDEF;
            tick();
            f = obs / F_TOT;
            if (d_en === 1'b1) begin
                if (f == 0) begin
                    pop_check("solid_frame0_stream");
                end else begin
                    total++;
                    if (rgb_out !== ((f == 1) ? 24'h123456 : 24'hABCDEF)) begin
                        bad++;
                        $display("FAIL solid_colour obs=%0d got=%h", obs, rgb_out);
                    end
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        do_reset(2'd3);
        while (cyc < 30) tick();
        total++;
        if (d_en !== 1'b1) begin
            bad++;
            $display("FAIL midreset_pre_den got=%b required=1", d_en);
        end
        rst = 1'b1;
        #1;
        total++;
        if ({rgb_out, d_en, hsync, vsync, frame_start, disp_en, underflow, d_clk} !==
            {24'h0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            bad++;
            $display("FAIL midreset_async got rgb=%h den=%b hs=%b vs=%b fs=%b de=%b uf=%b dclk=%b",
                     rgb_out, d_en, hsync, vsync, frame_start, disp_en, underflow, d_clk);
        end
        @(negedge clk_12mhz);
        @(negedge clk_12mhz);
        rst = 1'b0;
        cyc = 0;
        repeat (3) begin
            tick();
            total++;
            if ({hsync, vsync, frame_start, d_en} !== {(obs >= 2), 1'b0, (obs == 0), 1'b0}) begin
                bad++;
                $display("FAIL midreset_restart obs=%0d got hs/vs/fs/den=%b%b%b%b", obs,
                         hsync, vsync, frame_start, d_en);
            end
        end
    endtask

    initial begin
        test_reset();
        test_blank();
        test_stream();
        test_underflow();
        test_mode_switch();
        test_solid();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
